pc_redirect_unit: RTL

Owns the program counter and turns the branching unit's decision into a fetch redirect. It sits directly downstream of the branch decision logic and feeds the instruction memory address and the pipeline-register flush controls. It selects between sequential, branch, JAL and JALR next-PC, squashes wrong-path instructions for a fixed number of cycles, and freezes fetch on halt.

---
 rtl/pc_redirect_unit_pkg.sv | 15 +
 rtl/pc_redirect_unit_if.sv | 38 +++
 rtl/pc_redirect_unit_pc_register.sv | 28 ++
 rtl/pc_redirect_unit.sv | 118 +++++++++++
 4 files changed

// File: rtl/pc_redirect_unit_pkg.sv
// Shared state encodings and constants for the PC redirect unit.
package pc_redirect_unit_pkg;

  typedef enum logic [1:0] {
    PC_RUN   = 2'b00,
    PC_FLUSH = 2'b01,
    PC_HALT  = 2'b10
  } pc_state_e;

  localparam int   PC_INC      = 4;
  localparam int   FLUSH_CNT_W = 3;
  localparam logic ONE         = 1'b1;
  localparam logic ZERO        = 1'b0;

endpackage

// File: rtl/pc_redirect_unit_if.sv
// Branch-decision to fetch-redirect bundle; master = branch/hazard side, slave = PC unit.
// Optional BR_STATS_EN adds the branch statistics counters to the bundle.
interface pc_redirect_if #(parameter int XLEN = 32);

  logic            is_branch;
  logic            branch;
  logic            jump;
  logic            jalr;
  logic [XLEN-1:0] target_addr;
  logic [XLEN-1:0] jalr_addr;
  logic            stall;
  logic            halt_req;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_plus4;
  logic            flush;
  logic            halted;
`ifdef BR_STATS_EN
  logic [31:0]     br_total_cnt;
  logic [31:0]     br_taken_cnt;
`endif

  modport master (
    output is_branch, branch, jump, jalr, target_addr, jalr_addr, stall, halt_req,
`ifdef BR_STATS_EN
    input  br_total_cnt, br_taken_cnt,
`endif
    input  pc, pc_plus4, flush, halted
  );

  modport slave (
    input  is_branch, branch, jump, jalr, target_addr, jalr_addr, stall, halt_req,
`ifdef BR_STATS_EN
    output br_total_cnt, br_taken_cnt,
`endif
    output pc, pc_plus4, flush, halted
  );

endinterface

// File: rtl/pc_redirect_unit_pc_register.sv
// XLEN-bit register with synchronous reset value and load enable; q updates one edge after en.
module pc_register #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VAL = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [XLEN-1:0] d,
  output logic [XLEN-1:0] q
);

  logic [XLEN-1:0] val_q;
  logic [XLEN-1:0] val_d;

  always_comb begin
    val_d = val_q;
    if (en) val_d = d;
  end

  always_ff @(posedge clk) begin
    if (rst) val_q <= RESET_VAL;
    else     val_q <= val_d;
  end

  assign q = val_q;

endmodule

// File: rtl/pc_redirect_unit.sv
// Program counter + redirect FSM (RUN/FLUSH/HALT); redirect at edge N gives pc=target after N.
// No backpressure: stall only holds pc; optional BR_STATS_EN adds branch counters.
module pc_redirect_unit
  import pc_redirect_unit_pkg::*;
#(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_PC     = '0,
  parameter int              FLUSH_CYCLES = 2
) (
  input  logic         clk,
  input  logic         rst,
  pc_redirect_if.slave bus
);

  localparam logic [FLUSH_CNT_W-1:0] FLUSH_INIT = FLUSH_CNT_W'(FLUSH_CYCLES - 1);

  pc_state_e              state_q, state_d;
  logic [FLUSH_CNT_W-1:0] cnt_q, cnt_d;
  logic                   pc_en;
  logic [XLEN-1:0]        pc_d;
  logic [XLEN-1:0]        pc_q;
  logic [XLEN-1:0]        pc_plus4;
  logic [XLEN-1:0]        jalr_tgt;
  logic                   redirect;

  assign pc_plus4 = pc_q + XLEN'(PC_INC);
  assign jalr_tgt = bus.jalr_addr & ~XLEN'(1);
  // A bare 'branch' without is_branch is noise from non-branch instructions.
  assign redirect = bus.jalr | bus.jump | (bus.is_branch & bus.branch);

  pc_register #(
    .XLEN      (XLEN),
    .RESET_VAL (RESET_PC)
  ) u_pc_reg (
    .clk (clk),
    .rst (rst),
    .en  (pc_en),
    .d   (pc_d),
    .q   (pc_q)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pc_en   = ZERO;
    pc_d    = pc_plus4;
    unique case (state_q)
      PC_RUN: begin
        if (bus.halt_req) begin
          state_d = PC_HALT;
        end else if (redirect) begin
          pc_en   = ONE;
          pc_d    = bus.jalr ? jalr_tgt : bus.target_addr;
          cnt_d   = FLUSH_INIT;
          state_d = PC_FLUSH;
        end else if (!bus.stall) begin
          pc_en = ONE;
        end
      end
      PC_FLUSH: begin
        // Redirects and halts seen here belong to squashed wrong-path instructions.
        pc_en = ~bus.stall;
        if (cnt_q == '0) state_d = PC_RUN;
        else             cnt_d   = cnt_q - 1'b1;
      end
      PC_HALT: begin
        state_d = PC_HALT;
      end
      default: begin
        state_d = PC_RUN;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= PC_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.pc       = pc_q;
  assign bus.pc_plus4 = pc_plus4;
  assign bus.flush    = (state_q == PC_FLUSH);
  assign bus.halted   = (state_q == PC_HALT);

`ifdef BR_STATS_EN
  logic [31:0] br_total_cnt_q, br_total_cnt_d;
  logic [31:0] br_taken_cnt_q, br_taken_cnt_d;

  always_comb begin
    br_total_cnt_d = br_total_cnt_q;
    br_taken_cnt_d = br_taken_cnt_q;
    if (state_q == PC_RUN && bus.is_branch && !bus.halt_req) begin
      br_total_cnt_d = br_total_cnt_q + 32'd1;
      if (bus.branch) br_taken_cnt_d = br_taken_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      br_total_cnt_q <= '0;
      br_taken_cnt_q <= '0;
    end else begin
      br_total_cnt_q <= br_total_cnt_d;
      br_taken_cnt_q <= br_taken_cnt_d;
    end
  end

  assign bus.br_total_cnt = br_total_cnt_q;
  assign bus.br_taken_cnt = br_taken_cnt_q;
`endif

endmodule
